// File: rtl/mprj_pwr_seq.sv
// Power sequencer for the two user-project supply domains: synchronizes and debounces the
// logic-high indicators, then steps clock enable, reset and interface enables in a fixed order.
module mprj_pwr_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STEP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       mprj_vdd_logic1,
    input  logic       mprj2_vdd_logic1,
    input  logic       seq_en_i,
    input  logic       fault_clr_i,
    output logic       user1_vcc_powergood,
    output logic       user2_vcc_powergood,
    output logic       user_clk_ena,
    output logic       user_rst_o,
    output logic       mprj_iena_wb,
    output logic       la_iena,
    output logic       seq_busy,
    output logic       seq_fault,
    output logic [2:0] seq_state
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DebMax   = DW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] StepLoad = SW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] TmoMax   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StWaitPg   = 3'd1,
        StClkOn    = 3'd2,
        StRstRel   = 3'd3,
        StRun      = 3'd4,
        StShutdown = 3'd5,
        StFault    = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      meta_q, sync_q;
    logic [DW-1:0]   deb_cnt_q [2];
    logic [SW-1:0]   step_cnt_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic            pg_all;
    logic            step_entry;

    // Index 0 is domain 1, index 1 is domain 2.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            meta_q       <= '0;
            sync_q       <= '0;
            deb_cnt_q[0] <= '0;
            deb_cnt_q[1] <= '0;
        end else begin
            meta_q <= {mprj2_vdd_logic1, mprj_vdd_logic1};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (!sync_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] != DebMax) begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    assign user1_vcc_powergood = (deb_cnt_q[0] == DebMax);
    assign user2_vcc_powergood = (deb_cnt_q[1] == DebMax);
    assign pg_all              = user1_vcc_powergood & user2_vcc_powergood;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StOff: begin
                if (seq_en_i) state_d = StWaitPg;
            end
            StWaitPg: begin
                if (!seq_en_i)                state_d = StOff;
                else if (pg_all)              state_d = StClkOn;
                else if (tmo_cnt_q == TmoMax) state_d = StFault;
            end
            StClkOn: begin
                if (!pg_all)                 state_d = StFault;
                else if (!seq_en_i)          state_d = StShutdown;
                else if (step_cnt_q == '0)   state_d = StRstRel;
            end
            StRstRel: begin
                if (!pg_all)                 state_d = StFault;
                else if (!seq_en_i)          state_d = StShutdown;
                else if (step_cnt_q == '0)   state_d = StRun;
            end
            StRun: begin
                if (!pg_all)                 state_d = StFault;
                else if (!seq_en_i)          state_d = StShutdown;
            end
            StShutdown: begin
                // Supply loss wins over a normal step expiry.
                if (!pg_all)                 state_d = StFault;
                else if (step_cnt_q == '0)   state_d = StOff;
            end
            StFault: begin
                if (fault_clr_i && !seq_en_i) state_d = StOff;
            end
            default: state_d = StOff;
        endcase
    end

    assign step_entry = (state_d != state_q) &&
                        (state_d == StClkOn || state_d == StRstRel || state_d == StShutdown);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StOff;
            step_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (step_entry) begin
                step_cnt_q <= StepLoad;
            end else if (step_cnt_q != '0) begin
                step_cnt_q <= step_cnt_q - SW'(1);
            end
            if (state_d == StWaitPg && state_q != StWaitPg) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StWaitPg) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        user_clk_ena = 1'b0;
        user_rst_o   = 1'b1;
        mprj_iena_wb = 1'b0;
        la_iena      = 1'b0;
        seq_busy     = 1'b0;
        seq_fault    = 1'b0;
        case (state_q)
            StWaitPg: seq_busy = 1'b1;
            StClkOn: begin
                user_clk_ena = 1'b1;
                seq_busy     = 1'b1;
            end
            StRstRel: begin
                user_clk_ena = 1'b1;
                user_rst_o   = 1'b0;
                seq_busy     = 1'b1;
            end
            StRun: begin
                user_clk_ena = 1'b1;
                user_rst_o   = 1'b0;
                mprj_iena_wb = 1'b1;
                la_iena      = 1'b1;
            end
            StShutdown: begin
                user_clk_ena = 1'b1;
                seq_busy     = 1'b1;
            end
            StFault: seq_fault = 1'b1;
            default: ;
        endcase
    end

    assign seq_state = state_q;

endmodule

// File: tb/tb_mprj_pwr_seq.sv
// Scoreboard bench for mprj_pwr_seq: stimulus schedules expected output vectors by edge number,
// a negedge monitor pops and compares them.
module tb_mprj_pwr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vdd1 = 1'b0;
    logic       vdd2 = 1'b0;
    logic       seq_en = 1'b0;
    logic       clr = 1'b0;
    logic       pg1, pg2, clk_ena, urst, iena_wb, iena_la, busy, fault;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    localparam int S_OFF = 0, S_WAIT = 1, S_CLKON = 2, S_RSTREL = 3, S_RUN = 4, S_SHUT = 5,
                   S_FAULT = 6;
    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_SEQ = 11'h1FF;

    typedef struct {
        int          at;
        logic [10:0] mask;
        logic [10:0] val;
        logic [95:0] name;
    } exp_t;

    exp_t q[$];

    mprj_pwr_seq dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .mprj_vdd_logic1     (vdd1),
        .mprj2_vdd_logic1    (vdd2),
        .seq_en_i            (seq_en),
        .fault_clr_i         (clr),
        .user1_vcc_powergood (pg1),
        .user2_vcc_powergood (pg2),
        .user_clk_ena        (clk_ena),
        .user_rst_o          (urst),
        .mprj_iena_wb        (iena_wb),
        .la_iena             (iena_la),
        .seq_busy            (busy),
        .seq_fault           (fault),
        .seq_state           (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Expected vector {pg1, pg2, clk_ena, rst, iena_wb, la_iena, busy, fault, state}.
    function automatic logic [10:0] ev(input logic [1:0] pg, input int st);
        logic c, r, w, l, b, f;
        c = 1'b0; r = 1'b1; w = 1'b0; l = 1'b0; b = 1'b0; f = 1'b0;
        case (st)
            S_WAIT:   b = 1'b1;
            S_CLKON:  begin c = 1'b1; b = 1'b1; end
            S_RSTREL: begin c = 1'b1; r = 1'b0; b = 1'b1; end
            S_RUN:    begin c = 1'b1; r = 1'b0; w = 1'b1; l = 1'b1; end
            S_SHUT:   begin c = 1'b1; b = 1'b1; end
            S_FAULT:  f = 1'b1;
            default: ;
        endcase
        return {pg, c, r, w, l, b, f, st[2:0]};
    endfunction

    function automatic void push(input int at, input logic [10:0] mask, input logic [10:0] val,
                                 input logic [95:0] name);
        exp_t e;
        int   i;
        e.at = at; e.mask = mask; e.val = val; e.name = name;
        i = 0;
        while (i < q.size() && q[i].at <= at) i++;
        q.insert(i, e);
    endfunction

    task automatic wait_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [10:0] act;
    assign act = {pg1, pg2, clk_ena, urst, iena_wb, iena_la, busy, fault, state};

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_n) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.at != edge_n) begin
                failures++;
                $display("FAIL %0s: scheduled edge %0d missed (now %0d)", e.name, e.at, edge_n);
            end else if ((act & e.mask) !== (e.val & e.mask)) begin
                failures++;
                $display("FAIL %0s @edge %0d: got %b required %b (mask %b)", e.name, edge_n,
                         act, e.val, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0, g0, h0, t0, t1, d0, v0;
        repeat (3) @(posedge clk);
        #1;
        e0 = edge_n;
        push(e0, M_ALL, ev(2'b00, S_OFF), "reset");

        // Nominal power-up with both indicators high from reset release.
        rst = 1'b0; vdd1 = 1'b1; vdd2 = 1'b1; seq_en = 1'b1;
        push(e0 + 1,  M_ALL, ev(2'b00, S_WAIT),   "nom_wait");
        push(e0 + 17, M_ALL, ev(2'b00, S_WAIT),   "nom_pg_pre");
        push(e0 + 18, M_ALL, ev(2'b11, S_WAIT),   "nom_pg");
        push(e0 + 19, M_ALL, ev(2'b11, S_CLKON),  "nom_clkon");
        push(e0 + 22, M_ALL, ev(2'b11, S_CLKON),  "nom_clk_end");
        push(e0 + 23, M_ALL, ev(2'b11, S_RSTREL), "nom_rstrel");
        push(e0 + 26, M_ALL, ev(2'b11, S_RSTREL), "nom_rr_end");
        push(e0 + 27, M_ALL, ev(2'b11, S_RUN),    "nom_run");

        // Orderly shutdown from RUN.
        r0 = e0 + 30;
        wait_to(r0);
        seq_en = 1'b0;
        push(r0 + 1, M_ALL, ev(2'b11, S_SHUT), "shut_entry");
        push(r0 + 4, M_ALL, ev(2'b11, S_SHUT), "shut_end");
        push(r0 + 5, M_ALL, ev(2'b11, S_OFF),  "shut_off");

        // Back up to RUN, then glitch domain 2 for one cycle.
        g0 = r0 + 8;
        wait_to(g0);
        seq_en = 1'b1;
        push(g0 + 2,  M_ALL, ev(2'b11, S_CLKON), "re_clkon");
        push(g0 + 10, M_ALL, ev(2'b11, S_RUN),   "re_run");
        h0 = g0 + 12;
        wait_to(h0);
        vdd2 = 1'b0;
        push(h0 + 2,  M_ALL, ev(2'b11, S_RUN),   "glt_pg_hold");
        push(h0 + 3,  M_ALL, ev(2'b10, S_RUN),   "glt_pg_drop");
        push(h0 + 4,  M_ALL, ev(2'b10, S_FAULT), "glt_fault");
        push(h0 + 7,  M_ALL, ev(2'b10, S_FAULT), "clr_ign");
        push(h0 + 8,  M_ALL, ev(2'b10, S_FAULT), "clr_ign2");
        push(h0 + 10, M_ALL, ev(2'b10, S_FAULT), "fault_hold");
        push(h0 + 12, M_ALL, ev(2'b10, S_OFF),   "clr_off");
        wait_to(h0 + 1);
        vdd2 = 1'b1;
        wait_to(h0 + 6);
        clr = 1'b1;
        wait_to(h0 + 7);
        clr = 1'b0;
        wait_to(h0 + 9);
        seq_en = 1'b0;
        wait_to(h0 + 11);
        clr = 1'b1;
        wait_to(h0 + 12);
        clr = 1'b0;

        // Timeout with domain 1 held low.
        t0 = h0 + 30;
        wait_to(t0);
        vdd1 = 1'b0;
        t1 = t0 + 5;
        wait_to(t1);
        seq_en = 1'b1;
        push(t1 + 1,    M_SEQ, ev(2'b00, S_WAIT),  "tmo_wait");
        push(t1 + 1024, M_SEQ, ev(2'b00, S_WAIT),  "tmo_pre");
        push(t1 + 1025, M_SEQ, ev(2'b00, S_FAULT), "tmo_fault");
        push(t1 + 1027, M_SEQ, ev(2'b00, S_OFF),   "tmo_clr");
        wait_to(t1 + 1026);
        seq_en = 1'b0;
        clr = 1'b1;
        wait_to(t1 + 1027);
        clr = 1'b0;

        // Debounce: domain 1 toggling with period 10, high 5.
        d0 = t1 + 1030;
        for (int k = 1; k <= 60; k++) push(d0 + k, M_ALL, ev(2'b01, S_WAIT), "deb_hold");
        for (int k = 0; k < 60; k++) begin
            wait_to(d0 + k);
            if (k == 0) seq_en = 1'b1;
            vdd1 = ((k % 10) < 5);
        end
        wait_to(d0 + 60);
        vdd1 = 1'b0;

        // Steady domain 1, then reset mid-sequence in RST_REL.
        v0 = d0 + 64;
        wait_to(v0);
        vdd1 = 1'b1;
        push(v0 + 17, M_ALL, ev(2'b01, S_WAIT),   "v_pg_pre");
        push(v0 + 18, M_ALL, ev(2'b11, S_WAIT),   "v_pg");
        push(v0 + 19, M_ALL, ev(2'b11, S_CLKON),  "v_clkon");
        push(v0 + 23, M_ALL, ev(2'b11, S_RSTREL), "v_rstrel");
        push(v0 + 25, M_ALL, ev(2'b00, S_OFF),    "mid_reset");
        push(v0 + 27, M_SEQ, ev(2'b00, S_OFF),    "post_reset");
        wait_to(v0 + 24);
        rst = 1'b1;
        wait_to(v0 + 26);
        rst = 1'b0;
        seq_en = 1'b0;

        wait_to(v0 + 30);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
